// File: rtl/zap_wb_arbiter_if.sv
// Per-master request fields plus the single registered Wishbone master port of zap_wb_arbiter.
// The arbiter uses the slave modport; the requesting cluster uses the master modport.
interface zap_wb_arbiter_if #(
    parameter int NUM_MASTERS = 3
);
    localparam int IW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]    i_wb_cyc_nxt;
    logic [NUM_MASTERS-1:0]    i_wb_stb_nxt;
    logic [NUM_MASTERS-1:0]    i_wb_wen_nxt;
    logic [4*NUM_MASTERS-1:0]  i_wb_sel_nxt;
    logic [32*NUM_MASTERS-1:0] i_wb_dat_nxt;
    logic [32*NUM_MASTERS-1:0] i_wb_adr_nxt;
    logic [3*NUM_MASTERS-1:0]  i_wb_cti_nxt;
    logic                      i_wb_ack;
    logic                      i_wb_err;

    logic [NUM_MASTERS-1:0]    o_ack;
    logic [NUM_MASTERS-1:0]    o_err;
    logic [IW-1:0]             o_grant_idx;

    logic                      o_wb_stb_nxt;
    logic                      o_wb_cyc_nxt;
    logic                      o_wb_wen_nxt;
    logic [3:0]                o_wb_sel_nxt;
    logic [31:0]               o_wb_dat_nxt;
    logic [31:0]               o_wb_adr_nxt;
    logic [2:0]                o_wb_cti_nxt;

    logic                      o_wb_stb;
    logic                      o_wb_cyc;
    logic                      o_wb_wen;
    logic [3:0]                o_wb_sel;
    logic [31:0]               o_wb_dat;
    logic [31:0]               o_wb_adr;
    logic [2:0]                o_wb_cti;

    modport slave (
        input  i_wb_cyc_nxt, i_wb_stb_nxt, i_wb_wen_nxt, i_wb_sel_nxt,
               i_wb_dat_nxt, i_wb_adr_nxt, i_wb_cti_nxt, i_wb_ack, i_wb_err,
        output o_ack, o_err, o_grant_idx,
               o_wb_stb_nxt, o_wb_cyc_nxt, o_wb_wen_nxt, o_wb_sel_nxt,
               o_wb_dat_nxt, o_wb_adr_nxt, o_wb_cti_nxt,
               o_wb_stb, o_wb_cyc, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
    );

    modport master (
        output i_wb_cyc_nxt, i_wb_stb_nxt, i_wb_wen_nxt, i_wb_sel_nxt,
               i_wb_dat_nxt, i_wb_adr_nxt, i_wb_cti_nxt, i_wb_ack, i_wb_err,
        input  o_ack, o_err, o_grant_idx,
               o_wb_stb_nxt, o_wb_cyc_nxt, o_wb_wen_nxt, o_wb_sel_nxt,
               o_wb_dat_nxt, o_wb_adr_nxt, o_wb_cti_nxt,
               o_wb_stb, o_wb_cyc, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
    );
endinterface

// File: rtl/zap_wb_arbiter.sv
// N-master Wishbone B3 arbiter/mux: fixed-priority or round-robin owner selection,
// optional CYC locking, registered master port and ACK/ERR routed to the owner only.
module zap_wb_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ARB_MODE    = 0,
    parameter int LOCK_ON_CYC = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    zap_wb_arbiter_if.slave bus
);
    localparam int            IW      = $clog2(NUM_MASTERS);
    localparam logic [IW-1:0] LAST    = IW'(NUM_MASTERS - 1);
    localparam logic [2:0]    CTI_EOB = 3'b111;

    logic [IW-1:0] r_state;
    logic [IW-1:0] r_rr_ptr;
    logic          r_wb_stb;
    logic          r_wb_cyc;
    logic          r_wb_wen;
    logic [3:0]    r_wb_sel;
    logic [31:0]   r_wb_dat;
    logic [31:0]   r_wb_adr;
    logic [2:0]    r_wb_cti;

    logic          w_boundary;
    logic          w_lock;
    logic          w_any_req;
    logic          w_arb;
    logic [IW-1:0] w_fp_idx;
    logic [IW-1:0] w_rr_idx;
    logic [IW-1:0] w_state_nxt;

    logic          w_stb_nxt;
    logic          w_cyc_nxt;
    logic          w_wen_nxt;
    logic [3:0]    w_sel_nxt;
    logic [31:0]   w_dat_nxt;
    logic [31:0]   w_adr_nxt;
    logic [2:0]    w_cti_nxt;

    // Wrap is an explicit compare so non-power-of-2 counts never reach an absent master.
    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] x);
        return (x == LAST) ? '0 : x + 1'b1;
    endfunction

    assign w_any_req  = |bus.i_wb_cyc_nxt;
    assign w_boundary = !r_wb_stb || bus.i_wb_ack || bus.i_wb_err;
    assign w_lock     = (LOCK_ON_CYC != 0) && r_wb_cyc && bus.i_wb_cyc_nxt[r_state];
    assign w_arb      = w_boundary && !w_lock && w_any_req;

    // Later indices overwrite earlier ones, so the highest requester wins.
    always_comb begin
        w_fp_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.i_wb_cyc_nxt[i]) w_fp_idx = IW'(i);
        end
    end

    always_comb begin
        logic [IW-1:0] v_cand;
        logic          v_found;
        w_rr_idx = r_rr_ptr;
        v_cand   = f_next(r_rr_ptr);
        v_found  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!v_found && bus.i_wb_cyc_nxt[v_cand]) begin
                w_rr_idx = v_cand;
                v_found  = 1'b1;
            end
            v_cand = f_next(v_cand);
        end
    end

    // Next-owner process; owner holds whenever the current beat is open, locked or nobody asks.
    always_comb begin
        w_state_nxt = r_state;
        if (w_arb) w_state_nxt = (ARB_MODE == 1) ? w_rr_idx : w_fp_idx;
    end

    // Output process: forward the next owner's fields and route responses to the current owner.
    always_comb begin
        w_cyc_nxt = bus.i_wb_cyc_nxt[w_state_nxt];
        w_stb_nxt = bus.i_wb_stb_nxt[w_state_nxt];
        w_wen_nxt = bus.i_wb_wen_nxt[w_state_nxt];
        w_sel_nxt = bus.i_wb_sel_nxt[w_state_nxt*4 +: 4];
        w_dat_nxt = bus.i_wb_dat_nxt[w_state_nxt*32 +: 32];
        w_adr_nxt = bus.i_wb_adr_nxt[w_state_nxt*32 +: 32];
        w_cti_nxt = bus.i_wb_cti_nxt[w_state_nxt*3 +: 3];

        bus.o_ack          = '0;
        bus.o_err          = '0;
        bus.o_ack[r_state] = r_wb_stb && bus.i_wb_ack;
        bus.o_err[r_state] = r_wb_stb && bus.i_wb_err;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= '0;
            r_rr_ptr <= LAST;
            r_wb_stb <= 1'b0;
            r_wb_cyc <= 1'b0;
            r_wb_wen <= 1'b0;
            r_wb_sel <= '0;
            r_wb_dat <= '0;
            r_wb_adr <= '0;
            r_wb_cti <= CTI_EOB;
        end else begin
            r_state  <= w_state_nxt;
            if (w_arb) r_rr_ptr <= w_state_nxt;
            r_wb_stb <= w_stb_nxt;
            r_wb_cyc <= w_cyc_nxt;
            r_wb_wen <= w_wen_nxt;
            r_wb_sel <= w_sel_nxt;
            r_wb_dat <= w_dat_nxt;
            r_wb_adr <= w_adr_nxt;
            r_wb_cti <= w_cti_nxt;
        end
    end

    assign bus.o_grant_idx  = r_state;
    assign bus.o_wb_stb_nxt = w_stb_nxt;
    assign bus.o_wb_cyc_nxt = w_cyc_nxt;
    assign bus.o_wb_wen_nxt = w_wen_nxt;
    assign bus.o_wb_sel_nxt = w_sel_nxt;
    assign bus.o_wb_dat_nxt = w_dat_nxt;
    assign bus.o_wb_adr_nxt = w_adr_nxt;
    assign bus.o_wb_cti_nxt = w_cti_nxt;
    assign bus.o_wb_stb     = r_wb_stb;
    assign bus.o_wb_cyc     = r_wb_cyc;
    assign bus.o_wb_wen     = r_wb_wen;
    assign bus.o_wb_sel     = r_wb_sel;
    assign bus.o_wb_dat     = r_wb_dat;
    assign bus.o_wb_adr     = r_wb_adr;
    assign bus.o_wb_cti     = r_wb_cti;
endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Three arbiter configurations (fixed+lock N=3, fixed legacy N=3, round-robin N=5) driven by
// burst-style masters; a queue scoreboard compares against an owner/pointer reference model.
module tb_zap_wb_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [73:0] RST_BUS = {1'b0, 1'b0, 1'b0, 4'h0, 3'b111, 32'h0, 32'h0};
    localparam int CFG_N    [3] = '{3, 3, 5};
    localparam int CFG_MODE [3] = '{0, 0, 1};
    localparam int CFG_LOCK [3] = '{1, 0, 0};

    typedef struct { logic [7:0] ack; logic [7:0] err; logic [73:0] nbus; } expc_t;
    typedef struct { logic [2:0] grant; logic [73:0] rbus; } expr_t;

    expc_t qc [3][$];
    expr_t qr [3][$];
    int    n_chk = 0;
    int    n_fail = 0;

    // stimulus-side master state
    int          rem  [3][8];
    logic [31:0] madr [3][8];
    logic [31:0] mdat [3][8];
    logic [3:0]  msel [3][8];
    logic        mwen [3][8];
    logic        mstb [3][8];

    // reference model state
    int          mo_owner [3];
    int          mo_ptr   [3];
    logic [73:0] mo_rbus  [3];

    logic [7:0]   s_cyc [3], s_stb [3], s_wen [3];
    logic [31:0]  s_sel [3];
    logic [23:0]  s_cti [3];
    logic [255:0] s_adr [3], s_dat [3];
    logic [2:0]   s_rst, s_ack, s_err;

    logic [7:0]  ob_ack [3], ob_err [3];
    logic [2:0]  ob_grant [3];
    logic [73:0] ob_nbus [3], ob_rbus [3];

    zap_wb_arbiter_if #(.NUM_MASTERS(3)) bus0 ();
    zap_wb_arbiter_if #(.NUM_MASTERS(3)) bus1 ();
    zap_wb_arbiter_if #(.NUM_MASTERS(5)) bus2 ();

    zap_wb_arbiter #(.NUM_MASTERS(3), .ARB_MODE(0), .LOCK_ON_CYC(1)) dut0 (
        .i_clk(clk), .i_reset(s_rst[0]), .bus(bus0));
    zap_wb_arbiter #(.NUM_MASTERS(3), .ARB_MODE(0), .LOCK_ON_CYC(0)) dut1 (
        .i_clk(clk), .i_reset(s_rst[1]), .bus(bus1));
    zap_wb_arbiter #(.NUM_MASTERS(5), .ARB_MODE(1), .LOCK_ON_CYC(0)) dut2 (
        .i_clk(clk), .i_reset(s_rst[2]), .bus(bus2));

    assign bus0.i_wb_cyc_nxt = s_cyc[0][2:0];
    assign bus0.i_wb_stb_nxt = s_stb[0][2:0];
    assign bus0.i_wb_wen_nxt = s_wen[0][2:0];
    assign bus0.i_wb_sel_nxt = s_sel[0][11:0];
    assign bus0.i_wb_cti_nxt = s_cti[0][8:0];
    assign bus0.i_wb_adr_nxt = s_adr[0][95:0];
    assign bus0.i_wb_dat_nxt = s_dat[0][95:0];
    assign bus0.i_wb_ack     = s_ack[0];
    assign bus0.i_wb_err     = s_err[0];

    assign bus1.i_wb_cyc_nxt = s_cyc[1][2:0];
    assign bus1.i_wb_stb_nxt = s_stb[1][2:0];
    assign bus1.i_wb_wen_nxt = s_wen[1][2:0];
    assign bus1.i_wb_sel_nxt = s_sel[1][11:0];
    assign bus1.i_wb_cti_nxt = s_cti[1][8:0];
    assign bus1.i_wb_adr_nxt = s_adr[1][95:0];
    assign bus1.i_wb_dat_nxt = s_dat[1][95:0];
    assign bus1.i_wb_ack     = s_ack[1];
    assign bus1.i_wb_err     = s_err[1];

    assign bus2.i_wb_cyc_nxt = s_cyc[2][4:0];
    assign bus2.i_wb_stb_nxt = s_stb[2][4:0];
    assign bus2.i_wb_wen_nxt = s_wen[2][4:0];
    assign bus2.i_wb_sel_nxt = s_sel[2][19:0];
    assign bus2.i_wb_cti_nxt = s_cti[2][14:0];
    assign bus2.i_wb_adr_nxt = s_adr[2][159:0];
    assign bus2.i_wb_dat_nxt = s_dat[2][159:0];
    assign bus2.i_wb_ack     = s_ack[2];
    assign bus2.i_wb_err     = s_err[2];

    assign ob_ack[0]   = 8'(bus0.o_ack);
    assign ob_err[0]   = 8'(bus0.o_err);
    assign ob_grant[0] = 3'(bus0.o_grant_idx);
    assign ob_nbus[0]  = {bus0.o_wb_cyc_nxt, bus0.o_wb_stb_nxt, bus0.o_wb_wen_nxt, bus0.o_wb_sel_nxt,
                          bus0.o_wb_cti_nxt, bus0.o_wb_adr_nxt, bus0.o_wb_dat_nxt};
    assign ob_rbus[0]  = {bus0.o_wb_cyc, bus0.o_wb_stb, bus0.o_wb_wen, bus0.o_wb_sel,
                          bus0.o_wb_cti, bus0.o_wb_adr, bus0.o_wb_dat};
    assign ob_ack[1]   = 8'(bus1.o_ack);
    assign ob_err[1]   = 8'(bus1.o_err);
    assign ob_grant[1] = 3'(bus1.o_grant_idx);
    assign ob_nbus[1]  = {bus1.o_wb_cyc_nxt, bus1.o_wb_stb_nxt, bus1.o_wb_wen_nxt, bus1.o_wb_sel_nxt,
                          bus1.o_wb_cti_nxt, bus1.o_wb_adr_nxt, bus1.o_wb_dat_nxt};
    assign ob_rbus[1]  = {bus1.o_wb_cyc, bus1.o_wb_stb, bus1.o_wb_wen, bus1.o_wb_sel,
                          bus1.o_wb_cti, bus1.o_wb_adr, bus1.o_wb_dat};
    assign ob_ack[2]   = 8'(bus2.o_ack);
    assign ob_err[2]   = 8'(bus2.o_err);
    assign ob_grant[2] = 3'(bus2.o_grant_idx);
    assign ob_nbus[2]  = {bus2.o_wb_cyc_nxt, bus2.o_wb_stb_nxt, bus2.o_wb_wen_nxt, bus2.o_wb_sel_nxt,
                          bus2.o_wb_cti_nxt, bus2.o_wb_adr_nxt, bus2.o_wb_dat_nxt};
    assign ob_rbus[2]  = {bus2.o_wb_cyc, bus2.o_wb_stb, bus2.o_wb_wen, bus2.o_wb_sel,
                          bus2.o_wb_cti, bus2.o_wb_adr, bus2.o_wb_dat};

    function automatic logic [2:0] cti_of(input int c, input int m);
        return (rem[c][m] > 1) ? 3'b010 : 3'b111;
    endfunction

    function automatic logic [73:0] bus_of(input int c, input int m);
        return {rem[c][m] > 0, mstb[c][m], mwen[c][m], msel[c][m], cti_of(c, m), madr[c][m], mdat[c][m]};
    endfunction

    // Winner by rule: highest requester, or first requester after the last winner going round.
    function automatic int pick(input int c, input logic [7:0] req);
        int n;
        n = CFG_N[c];
        if (CFG_MODE[c] == 0) begin
            for (int i = n - 1; i >= 0; i--) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= n; k++) if (req[(mo_ptr[c] + k) % n]) return (mo_ptr[c] + k) % n;
        end
        return mo_owner[c];
    endfunction

    task automatic chk(input string nm, input int c, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s actual=%h expected=%h t=%0t", c, nm, act, exp, $time);
        end
    endtask

    task automatic req_m(input int c, input int m, input int beats, input logic [31:0] adr);
        rem[c][m]  = beats;
        madr[c][m] = adr;
        mdat[c][m] = adr ^ 32'hA5A5_0000;
        msel[c][m] = 4'hF;
        mwen[c][m] = m[0];
    endtask

    task automatic drive_cfg(input int c, input bit rst, input bit a, input bit e, input int start_pct,
                             input int drop_pct, input int stb_pct, input bit push);
        int n, win, own;
        bit stb_now, cyc_now, run;
        logic [7:0] req;
        expc_t xc;
        expr_t xr;
        n       = CFG_N[c];
        own     = mo_owner[c];
        stb_now = mo_rbus[c][72];
        cyc_now = mo_rbus[c][73];
        // The owner sees its ACK/ERR in this cycle and presents its next beat right away.
        if (stb_now && (a || e) && rem[c][own] > 0) begin
            rem[c][own]--;
            madr[c][own] += 4;
        end
        req = '0;
        for (int m = 0; m < n; m++) begin
            if (rem[c][m] == 0 && $urandom_range(99) < start_pct) begin
                rem[c][m]  = $urandom_range(4, 1);
                madr[c][m] = $urandom() & 32'hFFFF_FFFC;
                mdat[c][m] = $urandom();
                msel[c][m] = 4'($urandom_range(15));
                mwen[c][m] = 1'($urandom_range(1));
            end else if (rem[c][m] > 0 && m != own && $urandom_range(99) < drop_pct) begin
                rem[c][m] = 0;
            end
            mstb[c][m] = (rem[c][m] > 0) && ($urandom_range(99) < stb_pct);
            req[m]     = rem[c][m] > 0;
            s_cyc[c][m]          = req[m];
            s_stb[c][m]          = mstb[c][m];
            s_wen[c][m]          = mwen[c][m];
            s_sel[c][4*m +: 4]   = msel[c][m];
            s_cti[c][3*m +: 3]   = cti_of(c, m);
            s_adr[c][32*m +: 32] = madr[c][m];
            s_dat[c][32*m +: 32] = mdat[c][m];
        end
        s_rst[c] = rst;
        s_ack[c] = a;
        s_err[c] = e;
        if (!push) return;

        xc.ack = (stb_now && a) ? (8'd1 << own) : 8'd0;
        xc.err = (stb_now && e) ? (8'd1 << own) : 8'd0;
        win = own;
        run = 1'b0;
        if ((!stb_now || a || e) && !(CFG_LOCK[c] != 0 && cyc_now && req[own]) && req != 0) begin
            run = 1'b1;
            win = pick(c, req);
        end
        xc.nbus = bus_of(c, win);
        qc[c].push_back(xc);
        if (rst) begin
            mo_owner[c] = 0;
            mo_ptr[c]   = n - 1;
            mo_rbus[c]  = RST_BUS;
        end else begin
            if (run) mo_ptr[c] = win;
            mo_owner[c] = win;
            mo_rbus[c]  = bus_of(c, win);
        end
        xr.grant = 3'(mo_owner[c]);
        xr.rbus  = mo_rbus[c];
        qr[c].push_back(xr);
    endtask

    task automatic cycle(input bit rst, input int ack_pct, input int err_pct, input int start_pct,
                         input int drop_pct, input int stb_pct, input bit push);
        bit a, e;
        @(posedge clk);
        #2;
        for (int c = 0; c < 3; c++) begin
            a = $urandom_range(99) < ack_pct;
            e = $urandom_range(99) < err_pct;
            drive_cfg(c, rst, a, e, start_pct, drop_pct, stb_pct, push);
        end
    endtask

    // Monitor: combinational results mid-cycle, registered results just after the edge.
    initial begin
        expc_t xc;
        expr_t xr;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                if (qc[c].size() > 0) begin
                    xc = qc[c].pop_front();
                    chk("o_ack", c, 80'(ob_ack[c]), 80'(xc.ack));
                    chk("o_err", c, 80'(ob_err[c]), 80'(xc.err));
                    chk("nxt_bus", c, 80'(ob_nbus[c]), 80'(xc.nbus));
                end
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < 3; c++) begin
                if (qr[c].size() > 0) begin
                    xr = qr[c].pop_front();
                    chk("grant_idx", c, 80'(ob_grant[c]), 80'(xr.grant));
                    chk("reg_bus", c, 80'(ob_rbus[c]), 80'(xr.rbus));
                end
            end
        end
    end

    initial begin
        s_rst = '1; s_ack = '0; s_err = '0;
        for (int c = 0; c < 3; c++) begin
            s_cyc[c] = '0; s_stb[c] = '0; s_wen[c] = '0; s_sel[c] = '0;
            s_cti[c] = '0; s_adr[c] = '0; s_dat[c] = '0;
            for (int m = 0; m < 8; m++) begin
                rem[c][m] = 0; madr[c][m] = '0; mdat[c][m] = '0;
                msel[c][m] = '0; mwen[c][m] = 1'b0; mstb[c][m] = 1'b0;
            end
            mo_owner[c] = 0;
            mo_ptr[c]   = CFG_N[c] - 1;
            mo_rbus[c]  = RST_BUS;
        end
        repeat (2) cycle(1'b1, 0, 0, 0, 0, 100, 1'b0);

        // idle after reset
        repeat (10) cycle(1'b0, 0, 0, 0, 0, 100, 1'b1);

        // masters 0 and 2 request together on an idle bus
        for (int c = 0; c < 3; c++) begin
            req_m(c, 0, 1, 32'h0000_0100);
            req_m(c, 2, 1, 32'h0000_0200);
        end
        repeat (4) cycle(1'b0, 100, 0, 0, 0, 100, 1'b1);

        // 4-beat burst from master 0; master 2 joins at beat 1
        for (int c = 0; c < 3; c++) req_m(c, 0, 4, 32'h0000_1000);
        repeat (2) cycle(1'b0, 100, 0, 0, 0, 100, 1'b1);
        for (int c = 0; c < 3; c++) req_m(c, 2, 1, 32'h0000_2000);
        repeat (10) cycle(1'b0, 100, 0, 0, 0, 100, 1'b1);

        // every master keeps asking for single beats, ACK every cycle
        repeat (14) begin
            for (int c = 0; c < 3; c++)
                for (int m = 0; m < CFG_N[c]; m++)
                    if (rem[c][m] == 0) req_m(c, m, 1, 32'h0000_3000 + 32'(m * 16));
            cycle(1'b0, 100, 0, 0, 0, 100, 1'b1);
        end
        repeat (6) cycle(1'b0, 100, 0, 0, 0, 100, 1'b1);

        // master 1 stalls without ACK, then reset lands mid-transfer
        for (int c = 0; c < 3; c++) begin
            for (int m = 0; m < 8; m++) rem[c][m] = 0;
            req_m(c, 1, 2, 32'h0000_4000);
        end
        repeat (4) cycle(1'b0, 0, 0, 0, 0, 100, 1'b1);
        cycle(1'b1, 0, 0, 0, 0, 100, 1'b1);
        repeat (5) cycle(1'b0, 100, 0, 0, 0, 100, 1'b1);

        // randomized traffic with occasional ERR, stalls, dropped requests and resets
        repeat (3000) cycle($urandom_range(99) == 0, 60, 8, 10, 3, 85, 1'b1);

        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
